// File: rtl/cpu_control.sv
// ---------------------------------------------------------------------------
// cpu_control
//
// Multicycle control FSM for the 16-bit CPU. Steps one instruction at a time
// through fetch (address + data), execute, and optional memory (address +
// data) phases, driving every datapath control plus the memory strobes.
//
// Optional build macro: WAIT_STATE_EN
//   defined   - FETCH_D and MEM_D stretch while MemReady is low; write-type
//               controls (IrWe, PcWe, RegWe, data-phase MemWrite) only fire
//               in the cycle MemReady is high.
//   undefined - MemReady is ignored; every memory phase is one cycle.
//
// Ports:
//   Clock      in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   Opcode     in   {IR[15:9], IR[2:0]}: class[9:8] fn[7:4] var[3] cond[2:0]
//   Flags      in   {Z,N,C,V}
//   MemReady   in   memory data-phase complete (wait-state builds only)
//   AluOp      out  ALU function
//   Op1Sel     out  ALU operand 1 select
//   PcSel      out  PC next-value select
//   Op2Sel..CFlag  out  single-bit datapath controls
//   MemRead    out  memory read strobe
//   MemWrite   out  memory write strobe
// ---------------------------------------------------------------------------

package opcodes;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_ADC   = 4'h2,
    ALU_SBC   = 4'h3,
    ALU_AND   = 4'h4,
    ALU_OR    = 4'h5,
    ALU_XOR   = 4'h6,
    ALU_NOT   = 4'h7,
    ALU_LSL   = 4'h8,
    ALU_LSR   = 4'h9,
    ALU_ASR   = 4'hA,
    ALU_ROL   = 4'hB,
    ALU_ROR   = 4'hC,
    ALU_PASS1 = 4'hD,
    ALU_PASS2 = 4'hE,
    ALU_CMP   = 4'hF
  } alu_functions_t;

  typedef enum logic [1:0] {
    Op1Rd1 = 2'b00,
    Op1Pc  = 2'b01,
    Op1Sp  = 2'b10,
    Op1Lr  = 2'b11
  } Op1_select_t;

  typedef enum logic [1:0] {
    Pc1   = 2'b00,
    PcLr  = 2'b01,
    PcImm = 2'b10
  } pc_select_t;

endpackage

module cpu_control
  import opcodes::*;
(
  input  logic           Clock,
  input  logic           nReset,
  input  logic [9:0]     Opcode,
  input  logic [3:0]     Flags,
  input  logic           MemReady,
  output alu_functions_t AluOp,
  output Op1_select_t    Op1Sel,
  output pc_select_t     PcSel,
  output logic           Op2Sel,
  output logic           Rw,
  output logic           WdSel,
  output logic           AluEn,
  output logic           SpEn,
  output logic           SpWe,
  output logic           LrEn,
  output logic           LrWe,
  output logic           LrSel,
  output logic           PcWe,
  output logic           PcEn,
  output logic           IrWe,
  output logic           ImmSel,
  output logic           RegWe,
  output logic           MemEn,
  output logic           Rs1Sel,
  output logic           CFlag,
  output logic           MemRead,
  output logic           MemWrite
);

  typedef enum logic [2:0] {
    RST     = 3'd0,
    FETCH_A = 3'd1,
    FETCH_D = 3'd2,
    EXEC    = 3'd3,
    MEM_A   = 3'd4,
    MEM_D   = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM     = 2'b10;
  localparam logic [1:0] CLS_BRANCH  = 2'b11;

  localparam logic [3:0] FN_ADC  = 4'b0010;
  localparam logic [3:0] FN_SBC  = 4'b0011;
  localparam logic [3:0] FN_CMP  = 4'b1111;
  localparam logic [3:0] FN_RET  = 4'b1111;
  localparam logic [3:0] FN_HALT = 4'b1110;

  state_t     state;
  state_t     next;
  logic [1:0] cls;
  logic [3:0] fn;
  logic       isvar;
  logic [2:0] cond;
  logic       flagz;
  logic       flagn;
  logic       flagc;
  logic       flagv;
  logic       taken;
  logic       ready;

  assign cls   = Opcode[9:8];
  assign fn    = Opcode[7:4];
  assign isvar = Opcode[3];
  assign cond  = Opcode[2:0];
  assign flagz = Flags[3];
  assign flagn = Flags[2];
  assign flagc = Flags[1];
  assign flagv = Flags[0];

  // Data-phase completion: with wait states the memory tells us when the
  // transfer is done, otherwise every data phase completes in one cycle.
`ifdef WAIT_STATE_EN
  assign ready = MemReady;
`else
  logic unusedMemReady;
  assign unusedMemReady = MemReady;
  assign ready = 1'b1;
`endif

  // State register; reset drops straight back to RST from any phase so an
  // instruction in flight is abandoned without completing its writes.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= RST;
    end else begin
      state <= next;
    end
  end

  // Branch condition decode against the current flags.
  always_comb begin
    taken = 1'b0;
    unique case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = flagz;
      3'b010:  taken = ~flagz;
      3'b011:  taken = flagc;
      3'b100:  taken = ~flagc;
      3'b101:  taken = flagn;
      3'b110:  taken = ~flagn;
      3'b111:  taken = flagv;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and output decode. Everything starts from the idle defaults
  // so each state only lists the controls it actually raises. SpEn, SpWe,
  // Rw and LrEn have no active use in this instruction set and stay low.
  always_comb begin
    next     = state;
    AluOp    = ALU_ADD;
    Op1Sel   = Op1Rd1;
    PcSel    = Pc1;
    Op2Sel   = 1'b0;
    Rw       = 1'b0;
    WdSel    = 1'b0;
    AluEn    = 1'b0;
    SpEn     = 1'b0;
    SpWe     = 1'b0;
    LrEn     = 1'b0;
    LrWe     = 1'b0;
    LrSel    = 1'b0;
    PcWe     = 1'b0;
    PcEn     = 1'b0;
    IrWe     = 1'b0;
    ImmSel   = 1'b0;
    RegWe    = 1'b0;
    MemEn    = 1'b0;
    Rs1Sel   = 1'b0;
    CFlag    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;

    unique case (state)
      RST: begin
        next = FETCH_A;
      end

      FETCH_A: begin
        PcEn    = 1'b1;
        MemRead = 1'b1;
        next    = FETCH_D;
      end

      // IR load and PC increment are both held back until the fetch data
      // is actually present, so a stalled fetch never skips an instruction.
      FETCH_D: begin
        MemEn = 1'b1;
        PcSel = Pc1;
        IrWe  = ready;
        PcWe  = ready;
        next  = ready ? EXEC : FETCH_D;
      end

      EXEC: begin
        next = FETCH_A;
        unique case (cls)
          CLS_ALU_REG, CLS_ALU_IMM: begin
            AluEn  = 1'b1;
            AluOp  = alu_functions_t'(fn);
            RegWe  = (fn != FN_CMP);
            Op2Sel = (cls == CLS_ALU_IMM);
            ImmSel = (cls == CLS_ALU_IMM);
            CFlag  = ((fn == FN_ADC) || (fn == FN_SBC)) ? flagc : 1'b0;
          end

          CLS_MEM: begin
            next = MEM_A;
          end

          CLS_BRANCH: begin
            // RET and HALT are dedicated encodings within the branch class
            // and take precedence over the condition field.
            if (fn == FN_RET) begin
              PcWe  = 1'b1;
              PcSel = PcLr;
            end else if (fn == FN_HALT) begin
              next = HALT;
            end else if (taken) begin
              PcWe   = 1'b1;
              PcSel  = PcImm;
              ImmSel = 1'b1;
              LrWe   = isvar;
              LrSel  = isvar;
            end
          end

          default: begin
            next = FETCH_A;
          end
        endcase
      end

      // Effective address = Rs1 + immediate; the read or write strobe is
      // raised early so the memory can start the access.
      MEM_A: begin
        AluEn    = 1'b1;
        AluOp    = ALU_ADD;
        ImmSel   = 1'b1;
        Op2Sel   = 1'b1;
        MemRead  = ~isvar;
        MemWrite = isvar;
        next     = MEM_D;
      end

      // Load writes memory data back to the register file; store routes
      // Rs1 through the ALU unchanged to supply the write data.
      MEM_D: begin
        next = ready ? FETCH_A : MEM_D;
        if (!isvar) begin
          MemEn = 1'b1;
          WdSel = 1'b1;
          RegWe = ready;
        end else begin
          Rs1Sel   = 1'b1;
          AluEn    = 1'b1;
          AluOp    = ALU_PASS1;
          MemWrite = ready;
        end
      end

      HALT: begin
        next = HALT;
      end

      default: begin
        next = RST;
      end
    endcase
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
Multicycle control FSM for the 16-bit CPU. Sits directly upstream of datapath: consumes its Opcode and Flags, and drives every datapath control input plus the external memory strobes. Sequences fetch, execute, memory and branch phases one instruction at a time.

Parameters:
None. Encodings for alu_functions_t, Op1_select_t and pc_select_t come from package opcodes.

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
Opcode  input  10  {IR[15:9], IR[2:0]} from datapath
Flags  input  4  {Z,N,C,V} = Flags[3:0]
MemReady  input  1  memory data-phase complete (used only with WAIT_STATE_EN)
AluOp  output  alu_functions_t  ALU function
Op1Sel  output  Op1_select_t  ALU operand 1 select
PcSel  output  pc_select_t  PC next-value select (Pc1, PcLr, PcImm)
Op2Sel, Rw, WdSel, AluEn, SpEn, SpWe, LrEn, LrWe, LrSel, PcWe, PcEn, IrWe, ImmSel, RegWe, MemEn, Rs1Sel, CFlag  output  1 each  datapath controls
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe

Behaviour:
- Opcode fields: class = Opcode[9:8] (00 ALU-reg, 01 ALU-imm, 10 memory, 11 branch); fn = Opcode[7:4]; var = Opcode[3]; cond = Opcode[2:0].
- States: RST, FETCH_A, FETCH_D, EXEC, MEM_A, MEM_D, HALT. State register is async-reset to RST. Outputs are combinational from state, Opcode and Flags.
- Defaults in every state: all 1-bit outputs 0, PcSel=Pc1, Op1Sel=Op1Rd1, AluOp=ALU_ADD. SpEn and SpWe are always 0. Rw is always 0.
- RST: defaults only. Go to FETCH_A on the first rising edge after nReset is released.
- FETCH_A: PcEn=1, MemRead=1. Next state FETCH_D.
- FETCH_D: MemEn=1, IrWe=1, PcWe=1, PcSel=Pc1. Next state EXEC.
- EXEC, ALU-reg: AluEn=1, Op2Sel=0, AluOp=fn, RegWe=1 unless fn=4'b1111 (CMP: flags only). Next state FETCH_A.
- EXEC, ALU-imm: as ALU-reg, plus ImmSel=1 and Op2Sel=1.
- CFlag = Flags[1] when fn is ADC (4'b0010) or SBC (4'b0011) in an ALU class. Otherwise CFlag=0.
- EXEC, memory: no outputs. Next state MEM_A.
- MEM_A: AluEn=1, AluOp=ALU_ADD, ImmSel=1, Op2Sel=1 (address = Rs1+imm). MemRead=~var, MemWrite=var. Next state MEM_D.
- MEM_D, load (var=0): MemEn=1, WdSel=1, RegWe=1.
- MEM_D, store (var=1): Rs1Sel=1, AluEn=1, AluOp=ALU_PASS1, MemWrite=1.
- MEM_D exits to FETCH_A.
- EXEC, branch: condition taken by cond: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 !N, 111 V.
  - Taken: PcWe=1, PcSel=PcImm, ImmSel=1. If var=1, also LrWe=1, LrSel=1 (link old PC).
  - fn=4'b1111 (RET): PcWe=1, PcSel=PcLr, ignoring cond.
  - fn=4'b1110 (HALT): next state HALT.
  - All other branch cases: next state FETCH_A.
- HALT: defaults. Leave only via reset.
- Reset mid-instruction: immediate return to RST. No partial writes.
- Latencies: ALU and branch 3 cycles; load and store 5 cycles, plus wait states.

Optional Feature:
WAIT_STATE_EN
- Defined: FETCH_D and MEM_D hold their state, with all outputs steady, while MemReady=0. IrWe, PcWe, RegWe and the write strobe act only in the cycle MemReady=1.
- Undefined: MemReady is ignored and every memory phase is exactly one cycle.

Test Plan:
- Reset, then release nReset → RST for 1 cycle; FETCH_A with PcEn=1, MemRead=1; next cycle IrWe=1, PcWe=1, PcSel=Pc1.
- Opcode class 00, fn=0001 → EXEC: AluEn=1, RegWe=1, AluOp=fn, Op2Sel=0; back to FETCH_A after 3 cycles total. fn=1111 → RegWe=0.
- Load (class 10, var 0) → MEM_A: AluEn=1, ImmSel=1, MemRead=1; MEM_D: MemEn=1, WdSel=1, RegWe=1; 5 cycles total. Store (var 1) → MemWrite=1 in MEM_A and MEM_D, RegWe=0.
- Branch cond=001, Flags=4'b1000 → PcWe=1, PcSel=PcImm. Flags=4'b0000 → PcWe=0. var=1 taken → LrWe=1, LrSel=1. fn=1111 → PcSel=PcLr.
- ADC with Flags[1]=1 → CFlag=1 in EXEC; ADD with Flags[1]=1 → CFlag=0. HALT fn → stays in HALT 10 cycles with all strobes 0 until nReset pulse.
- WAIT_STATE_EN, MemReady low 3 cycles in FETCH_D → IrWe=1 only in the 4th cycle; no PC increment before it; nReset asserted during the wait → returns to RST.
